// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch front end.
//               - RESET_PC_DEFAULT : fetch address after reset
//               - INSN_W           : instruction word width
//               - fetch_entry_t    : prefetch queue slot {pc, insn, filled}
//               - ptr_width()      : index width for a queue of given depth
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
    localparam int          INSN_W           = 32;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INSN_W-1:0] insn;
        logic              filled;
    } fetch_entry_t;

    // Index width of a power-of-two queue; pointers carry one extra wrap bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Prefetch queue storage with three pointers.
//               alloc_ptr - next slot handed to a new memory request
//               fill_ptr  - next slot to receive a (non-dropped) response
//               rd_ptr    - head slot presented to decode
//   Ports:
//     clock, reset_n          : clock, async active-low reset
//     alloc, alloc_pc         : allocate slot with this PC (unfilled)
//     fill, fill_insn         : write instruction to fill slot, mark filled
//     pop                     : consume head slot
//     flush                   : clear all pointers and filled bits
//     head_filled/pc/insn     : head slot contents
//     occupancy               : alloc_ptr - rd_ptr (allocated, unconsumed)
//     in_flight               : alloc_ptr - fill_ptr (awaiting response)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      alloc,
    input  logic [31:0]               alloc_pc,
    input  logic                      fill,
    input  logic [INSN_W-1:0]         fill_insn,
    input  logic                      pop,
    input  logic                      flush,
    output logic                      head_filled,
    output logic [31:0]               head_pc,
    output logic [INSN_W-1:0]         head_insn,
    output logic [ptr_width(QDEPTH):0] occupancy,
    output logic [ptr_width(QDEPTH):0] in_flight
);

    localparam int         PW      = ptr_width(QDEPTH);
    localparam logic [PW:0] C_PTR_ONE = (PW+1)'(1);

    fetch_entry_t r_slot [QDEPTH];
    logic [PW:0]  r_alloc_ptr;
    logic [PW:0]  r_fill_ptr;
    logic [PW:0]  r_rd_ptr;

    logic [PW-1:0] w_alloc_idx;
    logic [PW-1:0] w_fill_idx;
    logic [PW-1:0] w_rd_idx;

    assign w_alloc_idx = r_alloc_ptr[PW-1:0];
    assign w_fill_idx  = r_fill_ptr[PW-1:0];
    assign w_rd_idx    = r_rd_ptr[PW-1:0];

    // The three slot writes never target the same slot in one cycle: the
    // allocated slot is always unfilled and outside [rd, alloc), the fill
    // slot is allocated but unfilled, and the popped slot is filled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_slot[i] <= '0;
            end
        end else if (flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_slot[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) begin
                r_slot[w_alloc_idx].pc     <= alloc_pc;
                r_slot[w_alloc_idx].filled <= 1'b0;
                r_alloc_ptr                <= r_alloc_ptr + C_PTR_ONE;
            end
            if (fill) begin
                r_slot[w_fill_idx].insn   <= fill_insn;
                r_slot[w_fill_idx].filled <= 1'b1;
                r_fill_ptr                <= r_fill_ptr + C_PTR_ONE;
            end
            if (pop) begin
                r_slot[w_rd_idx].filled <= 1'b0;
                r_rd_ptr                <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    assign head_filled = r_slot[w_rd_idx].filled;
    assign head_pc     = r_slot[w_rd_idx].pc;
    assign head_insn   = r_slot[w_rd_idx].insn;
    assign occupancy   = r_alloc_ptr - r_rd_ptr;
    assign in_flight   = r_alloc_ptr - r_fill_ptr;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Decoupled instruction-fetch front end. Owns the fetch PC,
//               issues in-order requests to an arbitrary-latency instruction
//               memory, buffers responses in a prefetch queue and hands
//               {pc, insn} pairs to decode. A redirect flushes the queue and
//               arranges for stale in-flight responses to be discarded.
//   Ports:
//     clock, reset_n                 : clock, async active-low reset
//     imem_req_valid/addr/ready      : request channel to instruction memory
//     imem_rsp_valid/data            : in-order response channel
//     redirect_valid/pc              : restart fetch at redirect_pc
//     insn_valid/ready/pc/data       : decode handshake
//   Parameters:
//     RESET_PC : fetch address after reset
//     QDEPTH   : queue depth and outstanding-request limit (power of two, >=2)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req_valid,
    output logic [31:0]       imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INSN_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [31:0]       insn_pc,
    output logic [INSN_W-1:0] insn_data
);

    localparam int PW = ptr_width(QDEPTH);
    localparam int DW = $clog2(QDEPTH + 1);
    localparam int SW = PW + 2;

    logic [31:0]   r_f_pc;
    logic [DW-1:0] r_drop_cnt;

    logic [PW:0]   w_occupancy;
    logic [PW:0]   w_in_flight;
    logic          w_head_filled;
    logic [SW-1:0] w_credit_used;
    logic          w_accept;
    logic          w_dropping;
    logic          w_fill;
    logic          w_pop;
    logic [31:0]   w_redirect_target;
    logic [DW-1:0] w_drop_next;

    // Credits cover both live slots and responses still owed to a flushed
    // stream, so the total outstanding count never exceeds QDEPTH.
    assign w_credit_used = SW'(w_occupancy) + SW'(r_drop_cnt);

    // Gated by reset_n so the request is held low throughout reset.
    assign imem_req_valid = reset_n && (w_credit_used < SW'(QDEPTH)) && !redirect_valid;
    assign imem_req_addr  = r_f_pc;

    assign w_accept   = imem_req_valid && imem_req_ready;
    assign w_dropping = (r_drop_cnt != '0);
    assign w_fill     = imem_rsp_valid && !w_dropping && !redirect_valid;

    assign insn_valid = w_head_filled && !redirect_valid;
    assign w_pop      = insn_valid && insn_ready;

    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // On redirect every unanswered request of the live stream joins the drop
    // count; a response arriving that same cycle is discarded regardless, so
    // it is taken off in either case.
    always_comb begin
        w_drop_next = r_drop_cnt;
        if (redirect_valid) begin
            w_drop_next = r_drop_cnt + DW'(w_in_flight) - DW'(imem_rsp_valid);
        end else if (imem_rsp_valid && w_dropping) begin
            w_drop_next = r_drop_cnt - DW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_f_pc     <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_next;
            if (redirect_valid) begin
                r_f_pc <= w_redirect_target;
            end else if (w_accept) begin
                r_f_pc <= r_f_pc + 32'd4;
            end
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clock       (clock),
        .reset_n     (reset_n),
        .alloc       (w_accept),
        .alloc_pc    (r_f_pc),
        .fill        (w_fill),
        .fill_insn   (imem_rsp_data),
        .pop         (w_pop),
        .flush       (redirect_valid),
        .head_filled (w_head_filled),
        .head_pc     (insn_pc),
        .head_insn   (insn_data),
        .occupancy   (w_occupancy),
        .in_flight   (w_in_flight)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. An in-order memory model
//               with configurable latency answers requests; a stream model
//               tracks which PC decode must see next and which address the
//               next request must carry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0100_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic [31:0] insn_pc;
    logic [31:0] insn_data;

    always #5 clock = ~clock;

    fetch_unit #(
        .RESET_PC (RPC),
        .QDEPTH   (QD)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
        .insn_pc        (insn_pc),
        .insn_data      (insn_data)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: in-order queue of accepted requests with due cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    cyc = 0;
    int    mem_lat = 1;
    bit    rand_lat = 0;
    int    last_due = 0;

    // Stream model.
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    bit          pending;

    int          fires, consumes, first_fire_edge, first_valid_period;
    logic [31:0] first_pc;

    task automatic clear_stats();
        fires = 0;
        consumes = 0;
        first_fire_edge = -1;
        first_valid_period = -1;
        first_pc = '0;
    endtask

    // One clock: check at negedge, advance memory just after posedge.
    task automatic tick();
        bit          s_fire;
        bit          s_rsp;
        logic [31:0] s_addr;
        int          lat;
        int          due;
        @(negedge clock);
        if (reset_n) begin
            if (redirect_valid) begin
                chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
                chk("redir_insn_valid", {31'd0, insn_valid}, 32'd0);
            end else begin
                if (pending) chk("req_hold", {31'd0, imem_req_valid}, 32'd1);
                if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
                if (insn_valid) begin
                    chk("insn_pc", insn_pc, exp_pc);
                    chk("insn_data", insn_data, memf(exp_pc));
                    if (first_valid_period < 0) begin
                        first_valid_period = cyc;
                        first_pc = insn_pc;
                    end
                end
            end
        end
        s_fire = imem_req_valid && imem_req_ready;
        s_rsp  = imem_rsp_valid;
        s_addr = imem_req_addr;
        if (redirect_valid) begin
            exp_pc  = redirect_pc & 32'hFFFF_FFFC;
            exp_req = redirect_pc & 32'hFFFF_FFFC;
            pending = 0;
        end else begin
            if (s_fire) begin
                exp_req = exp_req + 32'd4;
                fires++;
                if (first_fire_edge < 0) first_fire_edge = cyc + 1;
            end
            if (insn_valid && insn_ready) begin
                exp_pc = exp_pc + 32'd4;
                consumes++;
            end
            pending = imem_req_valid && !imem_req_ready;
        end
        @(posedge clock);
        cyc++;
        #1;
        if (s_rsp && mq.size() > 0) void'(mq.pop_front());
        if (s_fire) begin
            lat = rand_lat ? int'($urandom_range(1, 6)) : mem_lat;
            due = cyc + lat;
            if (due < last_due) due = last_due;
            last_due = due;
            mq.push_back('{addr: s_addr, due: due});
        end
        chk("outstanding_bound", {31'd0, (mq.size() <= QD)}, 32'd1);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        insn_ready = 1'b0;
        imem_req_ready = 1'b1;
        rand_lat = 0;
        mq.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_insn_valid", {31'd0, insn_valid}, 32'd0);
        reset_n = 1'b1;
        cyc = 0;
        last_due = 0;
        exp_pc = RPC;
        exp_req = RPC;
        pending = 0;
        clear_stats();
        #1;
        chk("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("rel_req_addr", imem_req_addr, RPC);
    endtask

    typedef struct {
        int lat;
        bit rdy;
        int ncyc;
        int exp_fires;
        int exp_delay;
    } vec_t;

    vec_t tbl[5];
    int   f0, c0;

    initial begin
        tbl[0] = '{lat: 1, rdy: 0, ncyc: 20, exp_fires: 4,  exp_delay: 2};
        tbl[1] = '{lat: 2, rdy: 0, ncyc: 20, exp_fires: 4,  exp_delay: 3};
        tbl[2] = '{lat: 3, rdy: 0, ncyc: 25, exp_fires: 4,  exp_delay: 4};
        tbl[3] = '{lat: 5, rdy: 0, ncyc: 30, exp_fires: 4,  exp_delay: 6};
        tbl[4] = '{lat: 1, rdy: 1, ncyc: 20, exp_fires: 20, exp_delay: 2};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            mem_lat = tbl[i].lat;
            insn_ready = tbl[i].rdy;
            repeat (tbl[i].ncyc) tick();
            chk("tbl_fires", fires, tbl[i].exp_fires);
            chk("tbl_first_valid_delay", first_valid_period - first_fire_edge, tbl[i].exp_delay);
        end

        // Full queue, then a single consume frees exactly one credit.
        do_reset();
        mem_lat = 1;
        repeat (12) tick();
        chk("full_fires", fires, 4);
        chk("full_valid", {31'd0, insn_valid}, 32'd1);
        f0 = fires;
        c0 = consumes;
        insn_ready = 1'b1;
        tick();
        insn_ready = 1'b0;
        repeat (10) tick();
        chk("pulse_extra_fires", fires - f0, 1);
        chk("pulse_consumes", consumes - c0, 1);

        // Redirect with two requests outstanding at latency 3.
        do_reset();
        mem_lat = 3;
        repeat (2) tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0100_0103;
        tick();
        redirect_valid = 1'b0;
        chk("redir_drop_cnt", dut.r_drop_cnt, 2);
        chk("redir_new_addr", imem_req_addr, 32'h0100_0100);
        clear_stats();
        imem_req_ready = 1'b1;
        insn_ready = 1'b1;
        repeat (20) tick();
        chk("redir_first_pc", first_pc, 32'h0100_0100);
        chk("redir_delivered", {31'd0, (consumes > 0)}, 32'd1);
        chk("redir_drop_done", dut.r_drop_cnt, 0);

        // Redirect colliding with a response and a consume.
        do_reset();
        mem_lat = 1;
        insn_ready = 1'b1;
        repeat (8) tick();
        chk("coll_pre_valid", {31'd0, insn_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2000;
        tick();
        redirect_valid = 1'b0;
        clear_stats();
        repeat (12) tick();
        chk("coll_first_pc", first_pc, 32'h0000_2000);

        // Back-to-back redirects: only the second target survives.
        mem_lat = 2;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_4000;
        tick();
        redirect_pc = 32'h0000_8006;
        tick();
        redirect_valid = 1'b0;
        clear_stats();
        repeat (15) tick();
        chk("b2b_first_pc", first_pc, 32'h0000_8004);

        // Asynchronous reset with three entries filled.
        do_reset();
        mem_lat = 1;
        repeat (3) tick();
        imem_req_ready = 1'b0;
        repeat (5) tick();
        chk("mid_pre_valid", {31'd0, insn_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("mid_rst_insn_valid", {31'd0, insn_valid}, 32'd0);
        do_reset();
        insn_ready = 1'b1;
        repeat (10) tick();
        chk("mid_restart_pc", first_pc, RPC);

        // Randomized traffic against the stream model.
        do_reset();
        rand_lat = 1;
        for (int n = 0; n < 3000; n++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            insn_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                if ($urandom_range(0, 3) == 0)
                    redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else
                    redirect_pc = $urandom();
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        chk("rand_progress", {31'd0, (consumes > 100)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the RISC-V core, replacing the fixed single-cycle PC/imemory path with a decoupled fetcher. It owns the fetch PC and issues in-order requests to an instruction memory with arbitrary latency. Returned instructions are buffered in a prefetch queue of configurable depth, and {pc, insn} pairs are delivered to decode over a valid/ready handshake. A redirect input (branch, JAL, JALR) flushes the queue and discards stale in-flight responses.

## Interface

Parameters:
- RESET_PC, 32'h01000000, fetch address after reset
- QDEPTH, 4, prefetch queue entries; power of two, at least 2; also the maximum number of outstanding requests

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address; bits [1:0] always 0
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_rsp_valid  in  1  response valid; responses return strictly in request order
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0
- insn_valid  out  1  head queue entry is filled
- insn_ready  in  1  decode consumes the head entry
- insn_pc  out  32  PC of the head entry
- insn_data  out  32  instruction of the head entry

## Operation

- State:
  - fetch PC f_pc.
  - Queue slots, each holding {pc, insn, filled}.
  - Three pointers: alloc_ptr, fill_ptr, rd_ptr.
  - drop_cnt, width clog2(QDEPTH+1).
- occupancy = alloc_ptr − rd_ptr, with one extra wrap bit. This counts slots that are allocated but not yet consumed, including slots still in flight.
- Issue:
  - imem_req_valid = (occupancy + drop_cnt < QDEPTH) && !redirect_valid.
  - imem_req_addr = f_pc.
- On request accept (valid && ready):
  - Allocate slot alloc_ptr with pc = f_pc and filled = 0.
  - Increment alloc_ptr.
  - f_pc ← f_pc + 4, wrapping modulo 2^32.
- Response handling, when imem_rsp_valid:
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise: write insn into slot fill_ptr, set filled, increment fill_ptr.
- Output:
  - insn_valid = slot[rd_ptr].filled && !redirect_valid.
  - insn_pc and insn_data come from slot[rd_ptr].
- Consume: on insn_valid && insn_ready, clear filled and increment rd_ptr.
- Redirect has priority over every other event in the same cycle:
  - f_pc ← {redirect_pc[31:2], 2'b00}.
  - All pointers reset to 0; all filled bits cleared.
  - No request is issued and no consume occurs that cycle.
  - drop_cnt ← drop_cnt + (alloc_ptr − fill_ptr) − (imem_rsp_valid && drop_cnt == 0 ? 1 : 0). This counts all still-outstanding, non-dropped requests.
  - A response arriving in the redirect cycle is discarded. If drop_cnt was nonzero, it also decrements drop_cnt.
- Back-to-back redirects are legal. drop_cnt never exceeds QDEPTH, because the issue condition bounds it.
- Queue full (occupancy + drop_cnt == QDEPTH): imem_req_valid is 0. A consume frees a credit, and a request may be issued in the following cycle.
- imem_req_valid/addr stay stable until accepted. The only exception is a redirect, which deasserts valid for that cycle; the new address appears the next cycle.

## Timing

- Reset (asynchronous assert, synchronous release), while reset_n is low:
  - f_pc = RESET_PC; pointers, filled bits and drop_cnt = 0.
  - imem_req_valid = 0, insn_valid = 0.
- First cycle after release: imem_req_valid = 1, imem_req_addr = RESET_PC.
- Latency: request accepted at edge N with memory latency L gives response at cycle N+L, and insn_valid at cycle N+L+1 (the fill is registered).
- Throughput: with L ≤ QDEPTH−1 and insn_ready held high, one instruction per cycle in steady state.
- Redirect at edge R:
  - First new request at cycle R+1.
  - Earliest valid redirected instruction at R+1+L+1.
- Reset asserted mid-operation: immediate return to the reset state. In-flight responses are lost; the memory is reset with the same reset_n.

## Structure

- Package fetch_pkg holds:
  - RESET_PC default.
  - Instruction width constant (32).
  - fetch_entry_t typedef {pc, insn, filled}.
  - Pointer-width helper function.
- Sub-module fetch_queue holds the slot storage and the alloc/fill/rd pointers. Its ports are alloc, fill, pop and flush.
- fetch_unit holds f_pc, drop_cnt, the credit logic and the redirect logic.

## Test plan

- Reset release, L=1, insn_ready=1 → addresses 0x01000000, 0x01000004, … on consecutive cycles; insn_valid first high 2 cycles after the first accept; one instruction per cycle thereafter.
- QDEPTH=4, insn_ready=0 → exactly 4 requests issued, then imem_req_valid=0. Pulse insn_ready for one cycle → one consume and exactly one further request.
- L=3, redirect to 0x01000103 with 2 requests outstanding → f_pc=0x01000100, drop_cnt=2. The next 2 responses are discarded. The first delivered instruction has insn_pc=0x01000100.
- Redirect in the same cycle as imem_rsp_valid and insn_valid&&insn_ready → the response is dropped, no consume occurs, and insn_valid=0 that cycle.
- Redirects on two consecutive cycles → only the second target is fetched, and no stale instruction reaches decode.
- reset_n asserted mid-stream with 3 queue entries filled → outputs are immediately in the reset state; after release, fetch restarts at RESET_PC.
